// File: rtl/apb_arb_pkg.sv
// Shared types and default constants for the APB master arbiter and its
// round-robin arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } apb_state_e;

  localparam int unsigned DefNreq    = 4;
  localparam int unsigned DefAddrW   = 32;
  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefTimeout = 16;
  localparam int unsigned DefIdxW    = $clog2(DefNreq);

  // Index width that stays at least one bit wide for tiny requester counts.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: masked request vector in, one-hot grant and index out.
// The priority pointer advances past the winner whenever the grant strobe fires.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  localparam int unsigned IdxW = idx_width(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] mask_i,
  input  logic            grant_en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic [IdxW-1:0] ptr_q;
  logic [NREQ-1:0] eligible;
  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  assign eligible = req_i & ~mask_i;

  // Scan from the pointer upward, wrapping at NREQ; the first eligible bit wins.
  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = 32'(ptr_q) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IdxW'(cand);
      if (!valid_o && eligible[cand_idx]) begin
        valid_o           = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (grant_en_i && valid_o) begin
      ptr_q <= (idx_o == IdxW'(NREQ - 1)) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port among NREQ requesters in round-robin order,
// sequencing IDLE/SETUP/ACCESS with an optional pready timeout.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NREQ    = DefNreq,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned TIMEOUT = DefTimeout,
  localparam int unsigned IdxW   = idx_width(NREQ),
  localparam int unsigned CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ-1:0]        req_write_i,
  input  logic [NREQ*ADDR_W-1:0] req_addr_i,
  input  logic [NREQ*DATA_W-1:0] req_wdata_i,
  output logic [NREQ-1:0]        done_o,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   err_o,
  output logic [ADDR_W-1:0]      paddr,
  output logic [DATA_W-1:0]      pwdata,
  output logic                   pwrite,
  output logic                   psel,
  output logic                   penable,
  input  logic [DATA_W-1:0]      prdata,
  input  logic                   pready,
  input  logic                   pslverr
);

  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  apb_state_e        state_q;
  logic [NREQ-1:0]   owner_q;
  logic [CntW-1:0]   cnt_q;
  logic [NREQ-1:0]   gnt_oh;
  logic [IdxW-1:0]   gnt_idx;
  logic              gnt_valid;
  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr_i[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata_i[g*DATA_W +: DATA_W];
  end

  // The requester being acknowledged this cycle is masked so its stale level
  // is not granted again before it has seen the done pulse.
  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .clk_i      (pclk),
    .rst_ni     (presetn),
    .req_i      (req_i),
    .mask_i     (done_o),
    .grant_en_i (state_q == StIdle),
    .grant_o    (gnt_oh),
    .idx_o      (gnt_idx),
    .valid_o    (gnt_valid)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= StIdle;
      owner_q <= '0;
      cnt_q   <= '0;
      paddr   <= '0;
      pwdata  <= '0;
      pwrite  <= 1'b0;
      psel    <= 1'b0;
      penable <= 1'b0;
      done_o  <= '0;
      rdata_o <= '0;
      err_o   <= 1'b0;
    end else begin
      done_o  <= '0;
      rdata_o <= '0;
      err_o   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            state_q <= StSetup;
            owner_q <= gnt_oh;
            paddr   <= addr_arr[gnt_idx];
            pwdata  <= wdata_arr[gnt_idx];
            pwrite  <= req_write_i[gnt_idx];
            psel    <= 1'b1;
          end
        end
        StSetup: begin
          state_q <= StAccess;
          penable <= 1'b1;
          cnt_q   <= '0;
        end
        StAccess: begin
          // pready wins over a timeout expiring on the same edge.
          if (pready) begin
            state_q <= StIdle;
            psel    <= 1'b0;
            penable <= 1'b0;
            done_o  <= owner_q;
            err_o   <= pslverr;
            rdata_o <= pwrite ? '0 : prdata;
          end else if (TIMEOUT != 0 && cnt_q == TimeoutLast) begin
            state_q <= StIdle;
            psel    <= 1'b0;
            penable <= 1'b0;
            done_o  <= owner_q;
            err_o   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: a table of single transfers plus
// hand-written contention, stale-request and mid-transfer reset sequences.
module tb_apb_master_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned TO   = 4;

  logic               pclk    = 1'b0;
  logic               presetn = 1'b1;
  logic [NREQ-1:0]    req_i, req_write_i;
  logic [NREQ*AW-1:0] req_addr_i;
  logic [NREQ*DW-1:0] req_wdata_i;
  logic [NREQ-1:0]    done_o;
  logic [DW-1:0]      rdata_o;
  logic               err_o;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic               pwrite, psel, penable;
  logic [DW-1:0]      prdata;
  logic               pready, pslverr;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_master_arbiter #(
    .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .req_i       (req_i),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .done_o      (done_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pwrite      (pwrite),
    .psel        (psel),
    .penable     (penable),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prd;
    int          waits;      // ACCESS cycles with pready low; >= 100 means never ready
    bit          slverr;
    logic [3:0]  exp_done;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_en;     // cycles penable is high
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t, input int v);
    int          cyc, en, psel_cyc, done_cyc;
    logic [31:0] a_seen, w_seen, r;
    logic        wr_seen, e, psel_at_done;
    logic [3:0]  d;
    string       tag;
    tag = $sformatf("vec%0d", v);
    a_seen = '0; w_seen = '0; r = '0; wr_seen = 1'b0; e = 1'b0; psel_at_done = 1'b0; d = '0;
    @(negedge pclk);
    req_i[t.idx]                 = 1'b1;
    req_write_i[t.idx]           = t.wr;
    req_addr_i[t.idx*AW +: AW]   = t.addr;
    req_wdata_i[t.idx*DW +: DW]  = t.wdata;
    prdata  = t.prd;
    pslverr = t.slverr;
    pready  = 1'b0;
    cyc = 0; en = 0; psel_cyc = -1; done_cyc = -1;
    while (done_cyc < 0 && cyc < 40) begin
      @(negedge pclk);
      cyc++;
      if (psel && psel_cyc < 0) begin
        psel_cyc = cyc; a_seen = paddr; w_seen = pwdata; wr_seen = pwrite;
      end
      if (penable) begin
        en++;
        pready = (en > t.waits);
      end else begin
        pready = 1'b0;
      end
      if (done_o != '0) begin
        done_cyc = cyc; d = done_o; r = rdata_o; e = err_o; psel_at_done = psel;
        req_i[t.idx] = 1'b0;
      end
    end
    pready = 1'b0;
    check({tag, "_psel_cycle"}, psel_cyc, 1);
    check({tag, "_penable_cycles"}, en, t.exp_en);
    check({tag, "_done_cycle"}, done_cyc, 2 + t.exp_en);
    check({tag, "_done"}, d, t.exp_done);
    check({tag, "_rdata"}, r, t.exp_rdata);
    check({tag, "_err"}, e, t.exp_err);
    check({tag, "_paddr"}, a_seen, t.addr);
    check({tag, "_pwdata"}, w_seen, t.wdata);
    check({tag, "_pwrite"}, wr_seen, t.wr);
    check({tag, "_psel_at_done"}, psel_at_done, 0);
  endtask

  task automatic pulse_reset();
    @(negedge pclk);
    presetn = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
  endtask

  task automatic contention();
    int         order[5];
    int         exp_order[5];
    int         n, cyc;
    logic [3:0] one;
    exp_order = '{0, 1, 2, 3, 0};
    one = 4'b0001;
    n = 0; cyc = 0;
    pulse_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_write_i[i]        = 1'b0;
      req_addr_i[i*AW +: AW] = 32'h100 + 32'(i * 4);
    end
    pready = 1'b1;
    prdata = 32'h0BAD_0000;
    req_i  = 4'hF;
    while (n < 5 && cyc < 60) begin
      @(negedge pclk);
      cyc++;
      if (done_o != '0 && n > 0) check("contention_done_owner", done_o, one << order[n-1]);
      if (psel && !penable) begin
        order[n] = int'((paddr - 32'h100) >> 2);
        n++;
      end
    end
    check("contention_grant_count", n, 5);
    for (int k = 0; k < n; k++) check($sformatf("contention_grant%0d", k), order[k], exp_order[k]);
    req_i = '0;
    repeat (5) @(negedge pclk);
    pready = 1'b0;
  endtask

  task automatic stale_request();
    int cyc;
    cyc = 0;
    req_write_i[0]         = 1'b0;
    req_addr_i[0 +: AW]    = 32'h300;
    pready = 1'b1;
    @(negedge pclk);
    req_i[0] = 1'b1;
    while (done_o == '0 && cyc < 20) begin
      @(negedge pclk);
      cyc++;
    end
    check("stale_done_seen", done_o, 4'b0001);
    @(negedge pclk);
    check("stale_no_regrant_in_done_cycle", psel, 0);
    @(negedge pclk);
    check("stale_reposted_grant", psel, 1);
    req_i = '0;
    repeat (4) @(negedge pclk);
    pready = 1'b0;
  endtask

  task automatic reset_mid_access();
    int         cyc;
    logic [3:0] seen_done;
    cyc = 0; seen_done = '0;
    pready = 1'b0;
    req_write_i[1:0]    = 2'b00;
    req_addr_i[0 +: AW] = 32'h200;
    req_addr_i[AW +: AW] = 32'h204;
    @(negedge pclk);
    req_i = 4'b0001;
    @(negedge pclk);
    @(negedge pclk);
    check("rst_pre_penable", penable, 1);
    req_i   = 4'b0011;
    presetn = 1'b0;
    #1;
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_done", done_o, 0);
    check("rst_paddr", paddr, 0);
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    while (!psel && cyc < 10) begin
      @(negedge pclk);
      cyc++;
      seen_done = seen_done | done_o;
    end
    check("rst_no_done", seen_done, 0);
    check("rst_regrant_psel", psel, 1);
    check("rst_priority_req0", paddr, 32'h200);
    req_i  = '0;
    pready = 1'b1;
    repeat (4) @(negedge pclk);
    pready = 1'b0;
  endtask

  initial begin
    req_i = '0; req_write_i = '0; req_addr_i = '0; req_wdata_i = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #1 presetn = 1'b0;
    #1;
    check("reset_psel", psel, 0);
    check("reset_penable", penable, 0);
    check("reset_pwrite", pwrite, 0);
    check("reset_paddr", paddr, 0);
    check("reset_pwdata", pwdata, 0);
    check("reset_done", done_o, 0);
    check("reset_rdata", rdata_o, 0);
    check("reset_err", err_o, 0);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;

    vecs[0] = '{0, 1, 32'h10, 32'hA5A5_0001, 32'h0,         0,   0, 4'b0001, 32'h0,         0, 1};
    vecs[1] = '{2, 0, 32'h20, 32'h0,         32'hDEAD_BEEF, 3,   0, 4'b0100, 32'hDEAD_BEEF, 0, 4};
    vecs[2] = '{1, 0, 32'h30, 32'h0,         32'h1234_5678, 100, 0, 4'b0010, 32'h0,         1, 4};
    vecs[3] = '{3, 1, 32'h40, 32'h1111_2222, 32'h0,         0,   1, 4'b1000, 32'h0,         1, 1};
    vecs[4] = '{3, 0, 32'h44, 32'h0,         32'hCAFE_F00D, 0,   0, 4'b1000, 32'hCAFE_F00D, 0, 1};
    vecs[5] = '{0, 0, 32'h50, 32'h0,         32'h5555_AAAA, 3,   0, 4'b0001, 32'h5555_AAAA, 0, 4};
    vecs[6] = '{1, 0, 32'h54, 32'h0,         32'h0F0F_0F0F, 3,   1, 4'b0010, 32'h0F0F_0F0F, 1, 4};
    vecs[7] = '{2, 1, 32'h60, 32'h7777_8888, 32'hFFFF_FFFF, 2,   0, 4'b0100, 32'h0,         0, 3};

    for (int v = 0; v < 8; v++) begin
      run_vec(vecs[v], v);
      @(negedge pclk);
    end

    contention();
    stale_request();
    reset_mid_access();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
